// File: rtl/peak_det_pkg.sv
// Shared definitions for the PZC peak detector.
//   - det_state_e : detector FSM states (idle, above threshold, hold-off)
//   - WIDTH_CNT_W : width of the saturating samples-above-threshold counter
//   - event_w()   : width of a packed event record {amp, ts, width, pileup},
//                   amp in the MSBs and the pileup bit in the LSB
package peak_det_pkg;

    localparam int unsigned WIDTH_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAbove,
        StHoldoff
    } det_state_e;

    function automatic int unsigned event_w(int unsigned nbits_in, int unsigned nbits_ts);
        return nbits_in + nbits_ts + WIDTH_CNT_W + 1;
    endfunction

endpackage

// File: rtl/peak_event_reg.sv
// One-entry valid/ready holding register for detector events plus a sticky
// overflow flag.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load_i        an event is offered this clk
//   load_data_i   packed event record
//   ready_i       consumer accepts the held event
//   valid_o       event held on data_o until accepted
//   data_o        held event record
//   overflow_o    sticky: an offered event was dropped because the entry was full
module peak_event_reg #(
    parameter int unsigned EVENT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [EVENT_W-1:0] load_data_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [EVENT_W-1:0] data_o,
    output logic               overflow_o
);

    logic               valid_q, valid_d;
    logic [EVENT_W-1:0] data_q, data_d;
    logic               overflow_q, overflow_d;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        if (load_i) begin
            // An accept on the same clk frees the entry for the new event.
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                data_d  = load_data_i;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pzc_peak_detector.sv
// Threshold-qualified pulse finder on the baseline-corrected signed PZC output.
// Reports one event per pulse (peak amplitude, peak timestamp, width over
// threshold) through a one-entry valid/ready register; a hold-off window after
// each reported pulse suppresses undershoot retriggers.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_data     signed sample, in_valid strobes it
//   out_ready   consumer accepts the held event
//   out_valid   event held on out_amp/out_ts/out_width/out_pileup until accepted
//   overflow    sticky: event dropped because the output was full
// Optional feature: define PEAK_PILEUP_EN to flag pulses whose above-threshold
// part contains a dip followed by a rise (out_pileup); otherwise out_pileup is 0.
module pzc_peak_detector
    import peak_det_pkg::*;
#(
    parameter int unsigned NBITS_IN  = 28,
    parameter int          THRESHOLD = 2048,
    parameter int unsigned MIN_WIDTH = 2,
    parameter int unsigned HOLDOFF   = 16,
    parameter int unsigned NBITS_TS  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [NBITS_IN-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic signed [NBITS_IN-1:0] out_amp,
    output logic [NBITS_TS-1:0]        out_ts,
    output logic [WIDTH_CNT_W-1:0]     out_width,
    output logic                       out_pileup,
    output logic                       overflow
);

    localparam int unsigned EventW = event_w(NBITS_IN, NBITS_TS);
    localparam int unsigned HoCntW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic signed [NBITS_IN-1:0] Thresh = NBITS_IN'(THRESHOLD);
    localparam logic [WIDTH_CNT_W-1:0] WidthMax = '1;

    det_state_e                 state_q, state_d;
    logic [NBITS_TS-1:0]        ts_q, ts_d;
    logic signed [NBITS_IN-1:0] peak_q, peak_d;
    logic [NBITS_TS-1:0]        peak_ts_q, peak_ts_d;
    logic [WIDTH_CNT_W-1:0]     width_q, width_d;
    logic [HoCntW-1:0]          ho_cnt_q, ho_cnt_d;
    logic                       emit_q, emit_d;
    logic                       pileup;
    logic                       above;

`ifdef PEAK_PILEUP_EN
    logic signed [NBITS_IN-1:0] prev_q, prev_d;
    logic                       fell_q, fell_d;    // last sample was below its predecessor
    logic                       pileup_q, pileup_d;
    assign pileup = pileup_q;
`else
    assign pileup = 1'b0;
`endif

    assign above = in_data > Thresh;

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        peak_d    = peak_q;
        peak_ts_d = peak_ts_q;
        width_d   = width_q;
        ho_cnt_d  = ho_cnt_q;
        emit_d    = 1'b0;
`ifdef PEAK_PILEUP_EN
        prev_d    = prev_q;
        fell_d    = fell_q;
        pileup_d  = pileup_q;
`endif
        if (in_valid) begin
            ts_d = ts_q + NBITS_TS'(1);
            unique case (state_q)
                StIdle: begin
                    if (above) begin
                        state_d   = StAbove;
                        peak_d    = in_data;
                        peak_ts_d = ts_q;
                        width_d   = WIDTH_CNT_W'(1);
`ifdef PEAK_PILEUP_EN
                        prev_d    = in_data;
                        fell_d    = 1'b0;
                        pileup_d  = 1'b0;
`endif
                    end
                end
                StAbove: begin
                    if (above) begin
                        if (width_q != WidthMax) begin
                            width_d = width_q + WIDTH_CNT_W'(1);
                        end
                        // Strict compare keeps the earliest sample of a flat top.
                        if (in_data > peak_q) begin
                            peak_d    = in_data;
                            peak_ts_d = ts_q;
                        end
`ifdef PEAK_PILEUP_EN
                        if (fell_q && (in_data > prev_q)) begin
                            pileup_d = 1'b1;
                        end
                        fell_d = in_data < prev_q;
                        prev_d = in_data;
`endif
                    end else if (32'(width_q) >= MIN_WIDTH) begin
                        // Event fields stay in peak_q/peak_ts_q/width_q and are
                        // captured by the output register on the next clk.
                        emit_d = 1'b1;
                        if (HOLDOFF == 0) begin
                            state_d = StIdle;
                        end else begin
                            state_d  = StHoldoff;
                            ho_cnt_d = '0;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHoldoff: begin
                    if (32'(ho_cnt_q) == HOLDOFF - 1) begin
                        state_d = StIdle;
                    end else begin
                        ho_cnt_d = ho_cnt_q + HoCntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ts_q      <= '0;
            peak_q    <= '0;
            peak_ts_q <= '0;
            width_q   <= '0;
            ho_cnt_q  <= '0;
            emit_q    <= 1'b0;
`ifdef PEAK_PILEUP_EN
            prev_q    <= '0;
            fell_q    <= 1'b0;
            pileup_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            peak_q    <= peak_d;
            peak_ts_q <= peak_ts_d;
            width_q   <= width_d;
            ho_cnt_q  <= ho_cnt_d;
            emit_q    <= emit_d;
`ifdef PEAK_PILEUP_EN
            prev_q    <= prev_d;
            fell_q    <= fell_d;
            pileup_q  <= pileup_d;
`endif
        end
    end

    logic [EventW-1:0] event_in;
    logic [EventW-1:0] event_out;

    assign event_in = {peak_q, peak_ts_q, width_q, pileup};

    peak_event_reg #(
        .EVENT_W(EventW)
    ) u_event_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (emit_q),
        .load_data_i(event_in),
        .ready_i    (out_ready),
        .valid_o    (out_valid),
        .data_o     (event_out),
        .overflow_o (overflow)
    );

    assign {out_amp, out_ts, out_width, out_pileup} = event_out;

endmodule

// File: tb/tb_pzc_peak_detector.sv
module tb_pzc_peak_detector;

    localparam int NbitsIn = 28;
    localparam longint Th = 2048;
    localparam int MinW = 2;
    localparam int Ho = 16;
`ifdef PEAK_PILEUP_EN
    localparam bit PileupOn = 1'b1;
`else
    localparam bit PileupOn = 1'b0;
`endif

    logic clk;
    logic rst;
    logic signed [NbitsIn-1:0] in_data;
    logic in_valid;
    logic out_ready;

    logic out_valid, out_pileup, overflow;
    logic signed [NbitsIn-1:0] out_amp;
    logic [31:0] out_ts;
    logic [15:0] out_width;

    logic out_valid4, out_pileup4, overflow4;
    logic signed [NbitsIn-1:0] out_amp4;
    logic [3:0] out_ts4;
    logic [15:0] out_width4;

    pzc_peak_detector dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_amp   (out_amp),
        .out_ts    (out_ts),
        .out_width (out_width),
        .out_pileup(out_pileup),
        .overflow  (overflow)
    );

    // Narrow timestamp instance, same stimulus, to exercise wrap-around.
    pzc_peak_detector #(
        .NBITS_TS(4)
    ) dut_ts4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_valid (out_valid4),
        .out_amp   (out_amp4),
        .out_ts    (out_ts4),
        .out_width (out_width4),
        .out_pileup(out_pileup4),
        .overflow  (overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        longint          amp;
        longint unsigned ts;
        int unsigned     width;
        bit              pileup;
    } ev_t;

    longint          run_amp[$];   // above-threshold samples of the pulse in progress
    longint unsigned run_ts[$];
    int              ho_left;      // samples still to ignore after a reported pulse
    longint unsigned m_ts;
    bit              pend;         // event produced by the last clocked sample
    ev_t             pend_ev;
    bit              e_valid;
    ev_t             e_ev;
    bit              e_ovf;
    bit              synced = 1'b0;

    function automatic ev_t summarize();
        ev_t ev;
        ev.amp = run_amp[0];
        ev.ts = run_ts[0];
        for (int i = 1; i < run_amp.size(); i++) begin
            if (run_amp[i] > ev.amp) begin
                ev.amp = run_amp[i];
                ev.ts = run_ts[i];
            end
        end
        ev.width = (run_amp.size() > 65535) ? 65535 : run_amp.size();
        ev.pileup = 1'b0;
        if (PileupOn) begin
            for (int i = 1; i + 1 < run_amp.size(); i++) begin
                if (run_amp[i] < run_amp[i-1] && run_amp[i+1] > run_amp[i]) ev.pileup = 1'b1;
            end
        end
        return ev;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    function automatic void model_step(input logic r, input logic v, input longint d,
                                       input logic rdy);
        if (r) begin
            run_amp.delete();
            run_ts.delete();
            ho_left = 0;
            m_ts = 0;
            pend = 1'b0;
            e_valid = 1'b0;
            e_ev = '{amp: 0, ts: 0, width: 0, pileup: 1'b0};
            e_ovf = 1'b0;
            synced = 1'b1;
            return;
        end
        if (pend) begin
            if (!e_valid || rdy) begin
                e_valid = 1'b1;
                e_ev = pend_ev;
            end else begin
                e_ovf = 1'b1;
            end
        end else if (e_valid && rdy) begin
            e_valid = 1'b0;
        end
        pend = 1'b0;
        if (v) begin
            if (ho_left > 0) begin
                ho_left--;
            end else if (d > Th) begin
                run_amp.push_back(d);
                run_ts.push_back(m_ts);
            end else if (run_amp.size() > 0) begin
                if (run_amp.size() >= MinW) begin
                    pend_ev = summarize();
                    pend = 1'b1;
                    ho_left = Ho;
                end
                run_amp.delete();
                run_ts.delete();
            end
            m_ts++;
        end
    endfunction

    // Compare after the previous edge, then step the model with the inputs
    // that the next edge will clock in.
    always @(negedge clk) begin
        if (synced) begin
            check("valid", 64'(out_valid), 64'(e_valid));
            check("overflow", 64'(overflow), 64'(e_ovf));
            check("valid_ts4", 64'(out_valid4), 64'(e_valid));
            if (e_valid) begin
                check("amp", 64'(out_amp), 64'(e_ev.amp));
                check("ts", 64'(out_ts), 64'(e_ev.ts & 64'hFFFF_FFFF));
                check("width", 64'(out_width), 64'(e_ev.width));
                check("pileup", 64'(out_pileup), 64'(e_ev.pileup));
                check("ts4", 64'(out_ts4), 64'(e_ev.ts & 64'hF));
            end
        end
        model_step(rst, in_valid, longint'(in_data), out_ready);
    end

    // ---------------- stimulus ----------------
    int unsigned n_valid = 0;   // valid samples since reset == expected timestamp

    task automatic step(input logic r, input logic v, input logic signed [NbitsIn-1:0] d,
                        input logic rdy);
        rst = r;
        in_valid = v;
        in_data = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
        if (r) n_valid = 0;
        else if (v) n_valid++;
    endtask

    task automatic samp(input logic signed [NbitsIn-1:0] d, input logic rdy);
        step(1'b0, 1'b1, d, rdy);
    endtask

    function automatic logic signed [NbitsIn-1:0] rand_sample();
        int unsigned sel;
        int tmp;
        sel = $urandom_range(0, 99);
        if (sel < 40) tmp = int'($urandom_range(0, 4000)) - 2000;
        else if (sel < 55) tmp = 2040 + int'($urandom_range(0, 16));
        else if (sel < 95) tmp = 2049 + int'($urandom_range(0, 8000));
        else tmp = int'($urandom());
        return NbitsIn'(tmp);
    endfunction

    int unsigned ts_cap;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_amp", 64'(out_amp), 64'd0);
        check("rst_ts", 64'(out_ts), 64'd0);
        check("rst_width", 64'(out_width), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Basic pulse, held with out_ready low.
        samp(0, 0); samp(3000, 0); samp(5000, 0); samp(4000, 0); samp(1000, 0);
        check("t1_not_yet", 64'(out_valid), 64'd0);
        samp(0, 0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_amp", 64'(out_amp), 64'd5000);
        check("t1_ts", 64'(out_ts), 64'd2);
        check("t1_width", 64'(out_width), 64'd3);
        check("t1_ts4", 64'(out_ts4), 64'd2);
        samp(0, 1);
        check("t1_accepted", 64'(out_valid), 64'd0);
        repeat (20) samp(0, 1);

        // Glitch rejected; next pulse right after still triggers.
        samp(2500, 1); samp(0, 1); samp(3000, 1); samp(3000, 1); samp(0, 1);
        samp(0, 0);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_width", 64'(out_width), 64'd2);
        samp(0, 1);

        // Retrigger inside hold-off ignored, at 17 samples reported (flat top).
        samp(0, 0); samp(0, 0); samp(3000, 0); samp(3000, 0);
        repeat (10) samp(0, 0);
        check("t3_holdoff_ignored", 64'(out_valid), 64'd0);
        ts_cap = n_valid;
        samp(3000, 0); samp(3000, 0); samp(0, 0); samp(0, 0);
        check("t3_retrigger", 64'(out_valid), 64'd1);
        check("t5_flat_top_ts", 64'(out_ts), 64'(ts_cap));
        check("t5_flat_top_ts4", 64'(out_ts4), 64'(ts_cap % 16));

        // Second pulse while full: dropped, overflow set, held event unchanged.
        repeat (16) samp(0, 0);
        samp(4000, 0); samp(7000, 0); samp(0, 0); samp(0, 0);
        check("t4_held_valid", 64'(out_valid), 64'd1);
        check("t4_held_amp", 64'(out_amp), 64'd3000);
        check("t4_overflow", 64'(overflow), 64'd1);
        step(1'b1, 1'b0, 0, 1'b0);
        check("t4_rst_overflow", 64'(overflow), 64'd0);

        // out_ready raised exactly on the emit clk: no drop.
        samp(3000, 0); samp(3500, 0); samp(0, 0); samp(0, 0);
        check("t4b_first", 64'(out_amp), 64'd3500);
        repeat (15) samp(0, 0);
        samp(2600, 0); samp(2700, 0); samp(0, 0); samp(0, 1);
        check("t4b_valid", 64'(out_valid), 64'd1);
        check("t4b_amp", 64'(out_amp), 64'd2700);
        check("t4b_no_overflow", 64'(overflow), 64'd0);
        samp(0, 1);
        check("t4b_accepted", 64'(out_valid), 64'd0);

        // Exactly at threshold is not above.
        repeat (16) samp(0, 1);
        samp(2048, 0); samp(2048, 0); samp(0, 0); samp(0, 0); samp(0, 0);
        check("t5_eq_threshold", 64'(out_valid), 64'd0);

        // Reset mid-pulse discards it.
        samp(3000, 0); samp(3000, 0); samp(3000, 0);
        step(1'b1, 1'b1, 0, 1'b0);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_amp", 64'(out_amp), 64'd0);
        repeat (3) samp(0, 0);
        check("t6_no_event", 64'(out_valid), 64'd0);

        // Pile-up shaped pulse.
        samp(3000, 0); samp(6000, 0); samp(4000, 0); samp(5000, 0); samp(1000, 0); samp(0, 0);
        check("t6_pu_valid", 64'(out_valid), 64'd1);
        check("t6_pu_amp", 64'(out_amp), 64'd6000);
        check("t6_pu_width", 64'(out_width), 64'd4);
        check("t6_pileup", 64'(out_pileup), 64'(PileupOn));
        samp(0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 599) == 0, $urandom_range(0, 99) < 85, rand_sample(),
                 $urandom_range(0, 99) < 40);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
